mdu_seq: RTL and testbench

Parametrised multi-cycle multiply/divide unit for the CPU datapath, the sequential successor to the single-cycle combinational ALU. It executes signed and unsigned multiply and divide into a private HI/LO register pair over a configurable number of cycles. While an operation is in flight it raises `busy` so the pipeline stalls any instruction that touches HI/LO. It also supports direct HI/LO writes (mthi/mtlo) and continuous HI/LO reads (mfhi/mflo).

---
 rtl/mdu_seq.sv | 200 ++++++++++++++++++++
 tb/tb_mdu_seq.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide unit with a private HI/LO pair, busy/done handshake and mthi/mtlo writes.
// Build option: define MDU_MADD_EN to enable the madd/maddu accumulate ops (100/101).
module mdu_seq #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             hi_we,
    input  logic             lo_we,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
`ifdef MDU_MADD_EN
    localparam logic [2:0] OP_MADD  = 3'b100;
    localparam logic [2:0] OP_MADDU = 3'b101;
`endif

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state_r, state_s;
    logic [CW-1:0]       cnt_r, cnt_s;
    logic [2:0]          op_r;
    logic [WIDTH-1:0]    a_r, b_r;
    logic [WIDTH-1:0]    hi_r, lo_r;
    logic                busy_r, done_r;

    logic                accept_s;
    logic                last_s;
    logic                sgn_s;
    logic                neg_a_s, neg_b_s;
    logic [2*WIDTH-1:0]  ext_a_s, ext_b_s, prod_s;
    logic [WIDTH-1:0]    mag_a_s, mag_b_s, quo_mag_s, rem_mag_s;
    logic [WIDTH-1:0]    quo_s, rem_s;
    logic [2*WIDTH-1:0]  res_s;
    logic                commit_s;

    function automatic logic op_valid(input logic [2:0] o);
        logic v;
        case (o)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: v = 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU:                  v = 1'b1;
`endif
            default:                            v = 1'b0;
        endcase
        return v;
    endfunction

    function automatic logic [CW-1:0] op_cycles(input logic [2:0] o);
        logic [CW-1:0] n;
        case (o)
            OP_DIV, OP_DIVU: n = CW'(DIV_CYCLES);
            default:         n = CW'(MULT_CYCLES);
        endcase
        return n;
    endfunction

    assign accept_s = start && op_valid(op);
    assign last_s   = (state_r == RUN) && (cnt_r == CW'(1));

    // Next-state and counter logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = RUN;
                    cnt_s   = op_cycles(op);
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                cnt_s = cnt_r - CW'(1);
                if (cnt_r == CW'(1)) begin
                    state_s = IDLE;
                end else begin
                    state_s = RUN;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = {CW{1'b0}};
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= {CW{1'b0}};
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Result datapath from the latched operands; even opcodes are the signed variants.
    // Division works on magnitudes, so -2^(W-1)/-1 naturally yields LO=-2^(W-1), HI=0.
    always_comb begin
        sgn_s    = ~op_r[0];
        ext_a_s  = sgn_s ? {{WIDTH{a_r[WIDTH-1]}}, a_r} : {{WIDTH{1'b0}}, a_r};
        ext_b_s  = sgn_s ? {{WIDTH{b_r[WIDTH-1]}}, b_r} : {{WIDTH{1'b0}}, b_r};
        prod_s   = ext_a_s * ext_b_s;
        neg_a_s  = sgn_s & a_r[WIDTH-1];
        neg_b_s  = sgn_s & b_r[WIDTH-1];
        mag_a_s  = neg_a_s ? (-a_r) : a_r;
        mag_b_s  = neg_b_s ? (-b_r) : b_r;
        if (b_r != {WIDTH{1'b0}}) begin
            quo_mag_s = mag_a_s / mag_b_s;
            rem_mag_s = mag_a_s % mag_b_s;
        end else begin
            quo_mag_s = {WIDTH{1'b0}};
            rem_mag_s = {WIDTH{1'b0}};
        end
        quo_s    = (neg_a_s ^ neg_b_s) ? (-quo_mag_s) : quo_mag_s;
        rem_s    = neg_a_s ? (-rem_mag_s) : rem_mag_s;
        res_s    = {hi_r, lo_r};
        commit_s = 1'b0;
        case (op_r)
            OP_MULT, OP_MULTU: begin
                res_s    = prod_s;
                commit_s = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
                res_s    = {rem_s, quo_s};
                commit_s = (b_r != {WIDTH{1'b0}});
            end
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU: begin
                res_s    = {hi_r, lo_r} + prod_s;
                commit_s = 1'b1;
            end
`endif
            default: begin
                res_s    = {hi_r, lo_r};
                commit_s = 1'b0;
            end
        endcase
    end

    // Operand latch, HI/LO writes and commit, plus registered busy/done.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_r   <= 3'b000;
            a_r    <= {WIDTH{1'b0}};
            b_r    <= {WIDTH{1'b0}};
            hi_r   <= {WIDTH{1'b0}};
            lo_r   <= {WIDTH{1'b0}};
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_s == RUN);
            done_r <= last_s;
            if (state_r == IDLE) begin
                if (hi_we) begin
                    hi_r <= in1;
                end
                if (lo_we) begin
                    lo_r <= in1;
                end
                if (accept_s) begin
                    op_r <= op;
                    a_r  <= in1;
                    b_r  <= in2;
                end
            end else if (last_s && commit_s) begin
                hi_r <= res_s[2*WIDTH-1:WIDTH];
                lo_r <= res_s[WIDTH-1:0];
            end
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_mdu_seq.sv
// Randomized self-checking bench for mdu_seq against an arithmetic reference model of HI/LO.
module tb_mdu_seq;

    logic        clk = 1'b0;
    logic        reset, start, hi_we, lo_we;
    logic [2:0]  op;
    logic [31:0] in1, in2;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] m_hi, m_lo;

    mdu_seq #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .in1(in1), .in2(in2),
        .hi_we(hi_we), .lo_we(lo_we), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit madd_enabled();
`ifdef MDU_MADD_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit op_accepted(input logic [2:0] o);
        return (o <= 3'd3) || ((o == 3'd4 || o == 3'd5) && madd_enabled());
    endfunction

    function automatic int cycles_of(input logic [2:0] o);
        return (o == 3'd2 || o == 3'd3) ? 10 : 5;
    endfunction

    // Reference: update m_hi/m_lo as the architecture defines the op.
    function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        longint sp, sq;
        longint unsigned p, acc;
        sa = a;
        sb = b;
        sp = longint'(sa);
        sq = longint'(sb);
        case (o)
            3'd0, 3'd4: p = longint'(sp * sq);
            default:    p = longint'(longint'({32'd0, a}) * longint'({32'd0, b}));
        endcase
        case (o)
            3'd0, 3'd1: {m_hi, m_lo} = p;
            3'd4, 3'd5: begin
                acc = {m_hi, m_lo};
                {m_hi, m_lo} = acc + p;
            end
            3'd2: begin
                if (b == 32'd0) begin
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    m_lo = 32'h8000_0000;
                    m_hi = 32'd0;
                end else begin
                    m_lo = sa / sb;
                    m_hi = sa % sb;
                end
            end
            3'd3: begin
                if (b != 32'd0) begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
            default: begin
            end
        endcase
    endfunction

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = cycles_of(o);
        model(o, a, b);
        @(negedge clk);
        start = 1'b1; op = o; in1 = a; in2 = b;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < n; k++) begin
            check("busy_during_op", busy, 1'b1);
            check("done_during_op", done, 1'b0);
            @(negedge clk);
        end
        check("busy_after_op", busy, 1'b0);
        check("done_pulse", done, 1'b1);
        check("hi_result", hi, m_hi);
        check("lo_result", lo, m_lo);
        @(negedge clk);
        check("done_once", done, 1'b0);
    endtask

    task automatic try_ignored(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; op = o; in1 = a; in2 = b;
        @(negedge clk);
        start = 1'b0;
        check("ignored_busy", busy, 1'b0);
        check("ignored_lo", lo, m_lo);
        check("ignored_hi", hi, m_hi);
        @(negedge clk);
        check("ignored_done", done, 1'b0);
    endtask

    task automatic write_hilo(input logic hw, input logic lw, input logic [31:0] v);
        @(negedge clk);
        hi_we = hw; lo_we = lw; in1 = v;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        if (hw) m_hi = v;
        if (lw) m_lo = v;
        check("write_hi", hi, m_hi);
        check("write_lo", lo, m_lo);
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        int sel;
        reset = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = 3'd0; in1 = 32'd0; in2 = 32'd0;
        m_hi = 32'd0; m_lo = 32'd0;
        repeat (2) @(negedge clk);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        reset = 1'b0;

        run_op(3'd0, 32'hFFFF_FFFF, 32'd2);
        check("mult_hi_const", hi, 32'hFFFF_FFFF);
        run_op(3'd1, 32'hFFFF_FFFF, 32'd2);
        check("multu_hi_const", hi, 32'h0000_0001);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2);
        check("div_lo_const", lo, 32'hFFFF_FFFD);
        run_op(3'd3, 32'd7, 32'd2);
        check("divu_lo_const", lo, 32'd3);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf_lo_const", lo, 32'h8000_0000);
        check("div_ovf_hi_const", hi, 32'd0);

        write_hilo(1'b1, 1'b0, 32'h12);
        write_hilo(1'b0, 1'b1, 32'h34);
        run_op(3'd3, 32'd99, 32'd0);
        check("div0_hi_const", hi, 32'h12);
        check("div0_lo_const", lo, 32'h34);
        write_hilo(1'b1, 1'b1, 32'h5A5A_0001);

        // Start and HI write issued while busy must be dropped.
        @(negedge clk);
        start = 1'b1; op = 3'd0; in1 = 32'd3; in2 = 32'd4;
        @(negedge clk);
        start = 1'b0;
        check("busy_c1", busy, 1'b1);
        @(negedge clk);
        start = 1'b1; op = 3'd3; in1 = 32'hAA; in2 = 32'd3; hi_we = 1'b1;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0;
        repeat (3) @(negedge clk);
        check("busy_conc_end", busy, 1'b0);
        check("done_conc", done, 1'b1);
        check("hi_conc", hi, 32'd0);
        check("lo_conc", lo, 32'd12);
        @(negedge clk);
        check("busy_conc_drop", busy, 1'b0);
        m_hi = 32'd0; m_lo = 32'd12;

        // Reset mid-operation abandons the op.
        @(negedge clk);
        start = 1'b1; op = 3'd0; in1 = 32'd5; in2 = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_done", done, 1'b0);
        check("rst_mid_hi", hi, 32'd0);
        check("rst_mid_lo", lo, 32'd0);
        m_hi = 32'd0; m_lo = 32'd0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("rst_no_late_done", done, 1'b0);
            check("rst_no_late_lo", lo, 32'd0);
        end

        // Accumulate ops: present only with the build option.
        write_hilo(1'b1, 1'b0, 32'd0);
        write_hilo(1'b0, 1'b1, 32'd5);
        if (madd_enabled()) begin
            run_op(3'd4, 32'd3, 32'd4);
            check("madd_lo_const", lo, 32'd17);
        end else begin
            try_ignored(3'd4, 32'd3, 32'd4);
            check("madd_off_lo_const", lo, 32'd5);
        end
        try_ignored(3'd6, 32'd1, 32'd1);
        try_ignored(3'd7, 32'd2, 32'd3);

        for (int i = 0; i < 40; i++) begin
            ro  = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) rb = 32'd0;
            if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            if (sel == 2) rb = 32'($urandom_range(1, 16));
            if (sel == 3) rb = -32'($urandom_range(1, 16));
            if ($urandom_range(0, 3) == 0) write_hilo(1'($urandom), 1'($urandom), $urandom);
            if (op_accepted(ro)) run_op(ro, ra, rb);
            else try_ignored(ro, ra, rb);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
